// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle control unit.
// Contents: opcode and funct codes, ALU control codes, FSM state encoding,
// pc_src / alu_src_b encodings and fault cause codes.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] ASB_RT      = 2'd0;
    localparam logic [1:0] ASB_FOUR    = 2'd1;
    localparam logic [1:0] ASB_IMM     = 2'd2;
    localparam logic [1:0] ASB_IMM_SH2 = 2'd3;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM    = 4'd4,
        S_WB_R   = 4'd5,
        S_WB_MEM = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_HALTED = 4'd9,
        S_FAULT  = 4'd10
    } state_e;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU control map.
// Ports: funct (in)    - funct field of the instruction register
//        alu_ctrl (out) - ALU operation code (ADD when funct is illegal)
//        illegal (out)  - funct is not a supported R-type operation
module alu_decoder
    import cpu_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  logic [FUNCT_W-1:0] funct,
    output logic [3:0]         alu_ctrl,
    output logic               illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (funct)
            FUNCT_W'(FN_ADD): alu_ctrl = ALU_ADD;
            FUNCT_W'(FN_SUB): alu_ctrl = ALU_SUB;
            FUNCT_W'(FN_AND): alu_ctrl = ALU_AND;
            FUNCT_W'(FN_OR):  alu_ctrl = ALU_OR;
            FUNCT_W'(FN_SLT): alu_ctrl = ALU_SLT;
            default:          illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback
// over a unified memory with a req/ack handshake, traps illegal instructions
// and bus timeouts, and counts active cycles and retired instructions.
// Ports: clk, rst (sync, active-high); op, funct, alu_zero, mem_ack (in);
//        memory handshake (mem_req, mem_we, iord), data-path selects and
//        write enables (out); halted, fault, fault_code, cycle_cnt,
//        retired_cnt status (out).
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on ack
// DECODE   | dispatch on op, precompute branch target
// EXEC     | ALU operation for R-type / ADDI
// ADDR     | effective address for LW / SW
// MEM      | data memory access
// WB_R     | register write of ALU result
// WB_MEM   | register write of loaded data
// BRANCH   | BEQ compare, conditional PC load
// JUMP     | PC load from jump target
// HALTED   | HALT executed, terminal
// FAULT    | illegal instruction or bus timeout, terminal
module mc_control_fsm
    import cpu_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               alu_zero,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               reg_we,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [3:0]         alu_ctrl,
    output logic               halted,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   retired_cnt
);

    // Wait timer counts down from TIMEOUT; reaching zero without ack expires.
    localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    logic              wait_expired;
    logic [1:0]        fault_cause;
    logic              retire;
    logic [3:0]        dec_ctrl;
    logic              funct_illegal;
    logic              is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, is_halt;

    assign is_rtype = (op == OP_W'(OP_RTYPE));
    assign is_addi  = (op == OP_W'(OP_ADDI));
    assign is_lw    = (op == OP_W'(OP_LW));
    assign is_sw    = (op == OP_W'(OP_SW));
    assign is_beq   = (op == OP_W'(OP_BEQ));
    assign is_j     = (op == OP_W'(OP_J));
    assign is_halt  = (op == OP_W'(OP_HALT));

    assign wait_expired = (TIMEOUT != 0) && (wait_q == '0);

    alu_decoder #(.FUNCT_W(FUNCT_W)) u_alu_decoder (
        .funct    (funct),
        .alu_ctrl (dec_ctrl),
        .illegal  (funct_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_q     <= WAIT_LOAD;
            fault_code <= FC_NONE;
        end else begin
            state_q <= state_d;
            // Reload on every transition so FETCH and MEM start with a full budget.
            if (state_d != state_q) begin
                wait_q <= WAIT_LOAD;
            end else if (!mem_ack && (wait_q != '0)) begin
                wait_q <= wait_q - WAIT_W'(1);
            end
            if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
                fault_code <= fault_cause;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fault_cause = FC_NONE;
        retire      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                // An ack in the expiry cycle takes priority over the timeout.
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d     = S_FAULT;
                    fault_cause = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (is_rtype || is_addi) begin
                    state_d = S_EXEC;
                end else if (is_lw || is_sw) begin
                    state_d = S_ADDR;
                end else if (is_beq) begin
                    state_d = S_BRANCH;
                end else if (is_j) begin
                    state_d = S_JUMP;
                end else if (is_halt) begin
                    state_d = S_HALTED;
                    retire  = 1'b1;
                end else begin
                    state_d     = S_FAULT;
                    fault_cause = FC_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (is_rtype && funct_illegal) begin
                    state_d     = S_FAULT;
                    fault_cause = FC_ILLEGAL;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_ADDR: state_d = S_MEM;
            S_MEM: begin
                if (mem_ack) begin
                    if (is_sw) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB_MEM;
                    end
                end else if (wait_expired) begin
                    state_d     = S_FAULT;
                    fault_cause = FC_TIMEOUT;
                end
            end
            S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALTED, S_FAULT: state_d = state_q;
            default:           state_d = S_FETCH;
        endcase
    end

    // Gated by rst so a request in flight drops in the reset cycle itself.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ASB_RT;
        alu_ctrl   = ALU_AND;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = ASB_FOUR;
                    alu_ctrl  = ALU_ADD;
                    ir_we     = mem_ack;
                    pc_we     = mem_ack;
                end
                S_DECODE: begin
                    alu_src_b = ASB_IMM_SH2;
                    alu_ctrl  = ALU_ADD;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    if (is_rtype) begin
                        alu_src_b = ASB_RT;
                        alu_ctrl  = dec_ctrl;
                    end else begin
                        alu_src_b = ASB_IMM;
                        alu_ctrl  = ALU_ADD;
                    end
                end
                S_WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = is_rtype;
                end
                S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ASB_IMM;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = is_sw;
                end
                S_WB_MEM: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ASB_RT;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = PC_SRC_BRANCH;
                    pc_we     = alu_zero;
                end
                S_JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_JUMP;
                end
                default: ;
            endcase
        end
    end

    assign halted = (state_q == S_HALTED);
    assign fault  = (state_q == S_FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if ((state_q != S_HALTED) && (state_q != S_FAULT) && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire && (retired_cnt != '1)) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm (TIMEOUT=4): a cycle-by-cycle
// vector table for the main instruction flows plus directed sequences for
// memory wait, faults, timeout, halt and reset during a transfer.
module tb_mc_control_fsm;

    typedef logic [16:0] ov_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       ack;
        ov_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ack;
    logic        mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic        reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_ctrl;
    logic        halted, fault;
    logic [1:0]  fault_code;
    logic [31:0] cycle_cnt, retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];

    ov_t F_ACK, F_WAIT, DEC, EXEC_I, WBR_R, WBR_I, ADDR, MEM_SW, MEM_LW, WBM, BR_T, BR_N, JMP;

    always #5 clk = ~clk;

    mc_control_fsm #(
        .OP_W(6), .FUNCT_W(6), .CNT_W(32), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .halted(halted),
        .fault(fault), .fault_code(fault_code), .cycle_cnt(cycle_cnt),
        .retired_cnt(retired_cnt)
    );

    function automatic ov_t ov(input logic req, input logic we, input logic io,
                               input logic irw, input logic pcw, input logic [1:0] pcs,
                               input logic rw, input logic rd, input logic m2r,
                               input logic asa, input logic [1:0] asb, input logic [3:0] ctl);
        return {req, we, io, irw, pcw, pcs, rw, rd, m2r, asa, asb, ctl};
    endfunction

    function automatic ov_t cur();
        return {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_ctrl};
    endfunction

    function automatic ov_t exec_r(input logic [3:0] ctl);
        return ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, ctl);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic z, input logic a);
        op = o; funct = f; alu_zero = z; mem_ack = a;
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic a, input ov_t e);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.ack = a; v.exp = e;
        vecs.push_back(v);
    endtask

    // Leaves the bench inside the first FETCH cycle, just after rst falls.
    task automatic do_reset();
        rst = 1'b1;
        set_in(6'h00, 6'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_outputs", 32'(cur()), 32'd0);
        check("rst_status", {28'd0, halted, fault, fault_code}, 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_retired_cnt", retired_cnt, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] fn_list[5];
        logic [3:0] ctl_list[5];

        F_ACK  = ov(1, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 2'd1, 4'b0010);
        F_WAIT = ov(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd1, 4'b0010);
        DEC    = ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd3, 4'b0010);
        EXEC_I = ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 4'b0010);
        WBR_R  = ov(0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0, 4'b0000);
        WBR_I  = ov(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 2'd0, 4'b0000);
        ADDR   = ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 4'b0010);
        MEM_SW = ov(1, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 4'b0000);
        MEM_LW = ov(1, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 4'b0000);
        WBM    = ov(0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 0, 2'd0, 4'b0000);
        BR_T   = ov(0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 1, 2'd0, 4'b0110);
        BR_N   = ov(0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 1, 2'd0, 4'b0110);
        JMP    = ov(0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 2'd0, 4'b0000);

        fn_list  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        ctl_list = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        for (int k = 0; k < 5; k++) begin
            add(6'h00, fn_list[k], 0, 1, F_ACK);
            add(6'h00, fn_list[k], 0, 1, DEC);
            add(6'h00, fn_list[k], 0, 1, exec_r(ctl_list[k]));
            add(6'h00, fn_list[k], 0, 1, WBR_R);
        end
        add(6'h08, 6'h00, 0, 1, F_ACK);  add(6'h08, 6'h00, 0, 1, DEC);
        add(6'h08, 6'h00, 0, 1, EXEC_I); add(6'h08, 6'h00, 0, 1, WBR_I);
        add(6'h2B, 6'h00, 0, 1, F_ACK);  add(6'h2B, 6'h00, 0, 1, DEC);
        add(6'h2B, 6'h00, 0, 1, ADDR);   add(6'h2B, 6'h00, 0, 1, MEM_SW);
        add(6'h23, 6'h00, 0, 1, F_ACK);  add(6'h23, 6'h00, 0, 1, DEC);
        add(6'h23, 6'h00, 0, 1, ADDR);   add(6'h23, 6'h00, 0, 1, MEM_LW);
        add(6'h23, 6'h00, 0, 1, WBM);
        add(6'h04, 6'h00, 1, 1, F_ACK);  add(6'h04, 6'h00, 1, 1, DEC);
        add(6'h04, 6'h00, 1, 1, BR_T);
        add(6'h04, 6'h00, 0, 1, F_ACK);  add(6'h04, 6'h00, 0, 1, DEC);
        add(6'h04, 6'h00, 0, 1, BR_N);
        add(6'h02, 6'h00, 0, 1, F_ACK);  add(6'h02, 6'h00, 0, 1, DEC);
        add(6'h02, 6'h00, 0, 1, JMP);

        // R-type ADD alone: 4 cycles, one retirement.
        do_reset();
        set_in(6'h00, 6'h20, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (c == 3) begin
                check("radd_reg_we", 32'(reg_we), 32'd1);
                check("radd_reg_dst", 32'(reg_dst), 32'd1);
            end
            next_cycle();
        end
        check("radd_retired", retired_cnt, 32'd1);
        check("radd_cycles", cycle_cnt, 32'd4);

        // Table: 11 instructions back to back, 42 cycles.
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].ack);
            #1;
            check($sformatf("vec%0d", i), 32'(cur()), 32'(vecs[i].exp));
            next_cycle();
        end
        check("table_retired", retired_cnt, 32'd11);
        check("table_cycles", cycle_cnt, 32'd42);

        // LW with ack delayed 3 cycles in MEM: request held 4 cycles, 8 total.
        do_reset();
        set_in(6'h23, 6'h00, 1'b0, 1'b1);
        next_cycle(); next_cycle(); next_cycle();
        for (int c = 0; c < 4; c++) begin
            mem_ack = (c == 3);
            #1;
            check($sformatf("lw_mem_hold%0d", c), 32'(cur()), 32'(MEM_LW));
            next_cycle();
        end
        #1;
        check("lw_wb_mem", 32'(cur()), 32'(WBM));
        next_cycle();
        check("lw_cycles", cycle_cnt, 32'd8);
        check("lw_retired", retired_cnt, 32'd1);

        // Illegal opcode: FAULT in cycle 3, counter frozen, rst recovers.
        do_reset();
        set_in(6'h11, 6'h00, 1'b0, 1'b1);
        next_cycle(); next_cycle();
        #1;
        check("illop_fault", 32'(fault), 32'd1);
        check("illop_code", 32'(fault_code), 32'd1);
        check("illop_outs", 32'(cur()), 32'd0);
        check("illop_cycles", cycle_cnt, 32'd2);
        repeat (5) next_cycle();
        #1;
        check("illop_frozen", cycle_cnt, 32'd2);
        check("illop_sticky", 32'(fault), 32'd1);
        do_reset();
        mem_ack = 1'b1;
        #1;
        check("illop_restart", 32'(cur()), 32'(F_ACK));

        // Illegal funct: FAULT after EXEC.
        do_reset();
        set_in(6'h00, 6'h21, 1'b0, 1'b1);
        next_cycle(); next_cycle(); next_cycle();
        #1;
        check("illfn_code", {28'd0, halted, fault, fault_code}, 32'h5);
        check("illfn_cycles", cycle_cnt, 32'd3);

        // Fetch timeout: 5 FETCH cycles without ack, then FAULT code 2.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("to_fetch%0d", c), 32'(cur()), 32'(F_WAIT));
            next_cycle();
        end
        #1;
        check("to_fault", {28'd0, halted, fault, fault_code}, 32'h6);
        check("to_req_drop", 32'(mem_req), 32'd0);
        next_cycle();
        #1;
        check("to_req_stays", 32'(mem_req), 32'd0);

        // Ack in the expiry cycle wins.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            mem_ack = (c == 4);
            #1;
            next_cycle();
        end
        #1;
        check("to_ack_wins_fault", 32'(fault), 32'd0);
        check("to_ack_wins_decode", 32'(cur()), 32'(DEC));

        // MEM timeout on a load.
        do_reset();
        set_in(6'h23, 6'h00, 1'b0, 1'b1);
        next_cycle(); next_cycle(); next_cycle();
        mem_ack = 1'b0;
        repeat (5) next_cycle();
        #1;
        check("to_mem_fault", {28'd0, halted, fault, fault_code}, 32'h6);
        check("to_mem_no_wb", retired_cnt, 32'd0);

        // Reset while a load waits in MEM: request drops at once, no writeback.
        do_reset();
        set_in(6'h23, 6'h00, 1'b0, 1'b1);
        next_cycle(); next_cycle(); next_cycle();
        mem_ack = 1'b0;
        #1;
        check("mid_mem_req", 32'(mem_req), 32'd1);
        next_cycle();
        rst = 1'b1;
        #1;
        check("mid_rst_outs", 32'(cur()), 32'd0);
        mem_ack = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("mid_rst_fetch", 32'(cur()), 32'(F_ACK));
        check("mid_rst_retired", retired_cnt, 32'd0);

        // HALT: retires, then ignores mem_ack with no strobes.
        do_reset();
        set_in(6'h3F, 6'h00, 1'b0, 1'b1);
        next_cycle(); next_cycle();
        #1;
        check("halt_flag", {28'd0, halted, fault, fault_code}, 32'h8);
        check("halt_retired", retired_cnt, 32'd1);
        for (int c = 0; c < 100; c++) begin
            mem_ack = c[0];
            #1;
            check($sformatf("halt_quiet%0d", c), {14'd0, halted, cur()}, {14'd0, 1'b1, 17'd0});
            next_cycle();
        end
        check("halt_cycles", cycle_cnt, 32'd2);
        check("halt_retired_end", retired_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the next-generation processor core. It replaces the single-cycle control path.
- Sequences fetch, decode, execute, memory and writeback over several cycles through a shared unified memory, using a req/ack handshake.
- Adds a bus timeout, illegal-instruction trapping, a sticky halt state, and cycle and retired-instruction counters.
- Sits beside the data path in the core top; drives all data-path mux selects and write enables.

Parameters:
- OP_W, 6, opcode field width.
- FUNCT_W, 6, R-type funct field width.
- CNT_W, 32, width of the cycle and retired counters.
- TIMEOUT, 255, maximum cycles waiting for mem_ack before fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  OP_W  opcode from the instruction register.
- funct  in  FUNCT_W  funct field from the instruction register.
- alu_zero  in  1  ALU zero flag.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write qualifier for mem_req.
- iord  out  1  memory address select: 0=PC, 1=ALU result register.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC load.
- pc_src  out  2  PC source: 0=ALU (PC+4), 1=branch target register, 2=jump target.
- reg_we  out  1  register file write.
- reg_dst  out  1  destination select: 0=rt, 1=rd.
- mem_to_reg  out  1  writeback select: 1=memory data register.
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B select: 0=rt, 1=constant 4, 2=sign-extended immediate, 3=sign-extended immediate shifted left 2.
- alu_ctrl  out  4  ALU operation.
- halted  out  1  HALT executed; sticky.
- fault  out  1  fault occurred; sticky.
- fault_code  out  2  fault cause: 0=none, 1=illegal instruction, 2=bus timeout.
- cycle_cnt  out  CNT_W  cycles spent outside HALTED and FAULT.
- retired_cnt  out  CNT_W  instructions completed.

Behaviour:
- Reset:
  - While rst=1, every strobe and select output is 0; state and all counters are cleared.
  - halted, fault and fault_code are cleared.
  - The first cycle after rst falls is FETCH.
- States: FETCH, DECODE, EXEC, ADDR, MEM, WB_R, WB_MEM, BRANCH, JUMP, HALTED, FAULT.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD.
  - On mem_ack: ir_we=1, pc_we=1, pc_src=0, go to DECODE. Otherwise stay in FETCH.
- DECODE (one cycle):
  - Outputs: alu_src_a=0, alu_src_b=3, alu_ctrl=ADD; precomputes the branch target.
  - Transitions by op:
    - R-type 0x00 -> EXEC
    - ADDI 0x08 -> EXEC
    - LW 0x23 -> ADDR
    - SW 0x2B -> ADDR
    - BEQ 0x04 -> BRANCH
    - J 0x02 -> JUMP
    - HALT 0x3F -> HALTED
    - any other op -> FAULT with code 1
- EXEC:
  - Outputs: alu_src_a=1.
  - R-type: alu_src_b=0, alu_ctrl from funct: 0x20 ADD=0010, 0x22 SUB=0110, 0x24 AND=0000, 0x25 OR=0001, 0x2A SLT=0111. Any other funct -> FAULT with code 1.
  - ADDI: alu_src_b=2, alu_ctrl=ADD.
  - Next state: WB_R.
- WB_R: reg_we=1; reg_dst=1 for R-type, 0 for ADDI; mem_to_reg=0; go to FETCH.
- ADDR: alu_src_a=1, alu_src_b=2, alu_ctrl=ADD; go to MEM.
- MEM:
  - Outputs: mem_req=1, iord=1, mem_we=1 for SW.
  - On mem_ack: SW -> FETCH, LW -> WB_MEM.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1; go to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_ctrl=SUB, pc_src=1, pc_we=alu_zero.
  - Next state: FETCH.
- JUMP: pc_we=1, pc_src=2; go to FETCH.
- HALTED, FAULT:
  - Terminal states; all strobes 0; halted or fault held at 1.
  - Only rst exits.
- Latency with mem_ack in the same cycle as mem_req: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3.
  - Each cycle a request waits for ack adds 1 cycle.
- Handshake:
  - mem_req, mem_we and iord stay stable until the ack cycle.
  - A transfer happens only when mem_req=1 and mem_ack=1.
  - mem_ack outside FETCH and MEM is ignored.
- Timeout:
  - A wait counter clears on entering FETCH or MEM and increments each cycle without ack.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with no ack, the next state is FAULT with code 2, and mem_req drops.
  - An ack arriving in that same cycle wins; no fault is raised.
- Counters:
  - retired_cnt increments in the final cycle of each instruction: WB_R, WB_MEM, SW MEM-ack, BRANCH, JUMP, and entry to HALTED.
  - cycle_cnt increments every cycle that is not in HALTED or FAULT.
  - Both counters saturate at all-ones.
- Reset mid-transaction (e.g. during MEM wait): mem_req drops in the rst cycle and the FSM restarts at FETCH. No partial writeback occurs.

Decomposition:
- cpu_pkg holds the opcode and funct constants, the ALU control codes, the state encoding, the pc_src and alu_src_b encodings, and the fault codes.
- One sub-module, alu_decoder: combinational map from funct to alu_ctrl plus an illegal flag. Instantiated by the FSM.

Test Plan:
- Reset, then op=0x00, funct=0x20, mem_ack tied 1 -> states FETCH, DECODE, EXEC, WB_R; reg_we=1 and reg_dst=1 in cycle 4; retired_cnt=1, cycle_cnt=4.
- LW with mem_ack delayed 3 cycles in MEM -> mem_req and iord=1 held steady for 4 cycles; WB_MEM asserts mem_to_reg=1; total 8 cycles.
- BEQ run twice, once with alu_zero=1 and once with 0 -> pc_we=1 with pc_src=1 in the first case, pc_we=0 in the second; each takes 3 cycles.
- op=0x11 -> FAULT in cycle 3 with fault=1, fault_code=1; cycle_cnt frozen at 2; rst then restarts FETCH with all outputs cleared.
- TIMEOUT=4 and mem_ack never asserted -> FAULT with fault_code=2 after 5 FETCH cycles; mem_req=0 afterwards. Repeat with ack arriving in the expiry cycle -> no fault.
- HALT -> halted=1 and retired_cnt incremented. Stays HALTED for 100 cycles while mem_ack toggles, with no strobes.
